// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one asynchronous ROM between instruction fetch (I) and data constant loads (D).
// Optional per-port grant/conflict/error counters are built when ROM_ARB_STATS_EN is defined.
module rom_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1432
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic [WIDTH-1:0] d_addr,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [31:0]      i_count,
    output logic [31:0]      d_count,
    output logic [31:0]      conflict_count,
    output logic [15:0]      err_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);

    state_t           state_r;
    state_t           next_state_s;
    logic             rr_last_r;
    logic             owner_r;
    logic             err_flag_r;
    logic [WIDTH-1:0] rom_address_r;
    logic             i_rvalid_r;
    logic [WIDTH-1:0] i_rdata_r;
    logic             i_err_r;
    logic             d_rvalid_r;
    logic [WIDTH-1:0] d_rdata_r;
    logic             d_err_r;
    logic             win_valid_s;
    logic             winner_s;
    logic [WIDTH-1:0] win_addr_s;

    // Misaligned word or word index past the end of the ROM.
    function automatic logic addr_err(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr[WIDTH-1:2] >= DEPTH_W);
    endfunction

    // Arbitration, grant generation and next-state selection.
    always_comb begin
        win_valid_s  = 1'b0;
        winner_s     = PORT_I;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req && d_req) begin
                    win_valid_s = 1'b1;
                    winner_s    = (rr_last_r == PORT_I) ? PORT_D : PORT_I;
                end else if (i_req) begin
                    win_valid_s = 1'b1;
                    winner_s    = PORT_I;
                end else if (d_req) begin
                    win_valid_s = 1'b1;
                    winner_s    = PORT_D;
                end else begin
                    win_valid_s = 1'b0;
                end
                next_state_s = win_valid_s ? ACCESS : IDLE;
            end
            ACCESS: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        win_addr_s = (winner_s == PORT_D) ? d_addr : i_addr;
        // Grants are suppressed while reset is applied so nothing is accepted then.
        i_gnt = nreset && win_valid_s && (winner_s == PORT_I);
        d_gnt = nreset && win_valid_s && (winner_s == PORT_D);
    end

    // Arbiter state, registered ROM address and per-port response registers.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_r       <= IDLE;
            rr_last_r     <= PORT_D;
            owner_r       <= PORT_I;
            err_flag_r    <= 1'b0;
            rom_address_r <= {WIDTH{1'b0}};
            i_rvalid_r    <= 1'b0;
            i_rdata_r     <= {WIDTH{1'b0}};
            i_err_r       <= 1'b0;
            d_rvalid_r    <= 1'b0;
            d_rdata_r     <= {WIDTH{1'b0}};
            d_err_r       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        rom_address_r <= win_addr_s;
                        owner_r       <= winner_s;
                        rr_last_r     <= winner_s;
                        err_flag_r    <= addr_err(win_addr_s);
                    end
                end
                ACCESS: begin
                    if (owner_r == PORT_D) begin
                        d_rvalid_r <= 1'b1;
                        d_err_r    <= err_flag_r;
                        d_rdata_r  <= err_flag_r ? {WIDTH{1'b0}} : rom_rdata;
                    end else begin
                        i_rvalid_r <= 1'b1;
                        i_err_r    <= err_flag_r;
                        i_rdata_r  <= err_flag_r ? {WIDTH{1'b0}} : rom_rdata;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rom_address = rom_address_r;
    assign i_rvalid    = i_rvalid_r;
    assign i_rdata     = i_rdata_r;
    assign i_err       = i_err_r;
    assign d_rvalid    = d_rvalid_r;
    assign d_rdata     = d_rdata_r;
    assign d_err       = d_err_r;

`ifdef ROM_ARB_STATS_EN
    logic [31:0] i_count_r;
    logic [31:0] d_count_r;
    logic [31:0] conflict_count_r;
    logic [15:0] err_count_r;

    // Event counters; all wrap naturally on overflow.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            i_count_r        <= 32'd0;
            d_count_r        <= 32'd0;
            conflict_count_r <= 32'd0;
            err_count_r      <= 16'd0;
        end else begin
            if (i_gnt) begin
                i_count_r <= i_count_r + 32'd1;
            end
            if (d_gnt) begin
                d_count_r <= d_count_r + 32'd1;
            end
            if ((state_r == IDLE) && i_req && d_req) begin
                conflict_count_r <= conflict_count_r + 32'd1;
            end
            if ((state_r == ACCESS) && err_flag_r) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end
    end

    assign i_count        = i_count_r;
    assign d_count        = d_count_r;
    assign conflict_count = conflict_count_r;
    assign err_count      = err_count_r;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter; the ROM is modelled as a pattern function.
module tb_rom_arbiter;

    logic        clock;
    logic        nreset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] rom_address;
    logic [31:0] rom_rdata;
`ifdef ROM_ARB_STATS_EN
    logic [31:0] i_count;
    logic [31:0] d_count;
    logic [31:0] conflict_count;
    logic [15:0] err_count;
`endif

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    rom_arbiter #(.WIDTH(32), .DEPTH(1432)) dut (
        .clock(clock),
        .nreset(nreset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_gnt(i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .i_err(i_err),
        .d_req(d_req),
        .d_addr(d_addr),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .d_err(d_err),
        .rom_address(rom_address),
        .rom_rdata(rom_rdata)
`ifdef ROM_ARB_STATS_EN
        ,
        .i_count(i_count),
        .d_count(d_count),
        .conflict_count(conflict_count),
        .err_count(err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input int idx);
        return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0101);
    endfunction

    // Asynchronous ROM; returns a poison value for any address the arbiter must reject.
    always_comb begin
        if ((rom_address[1:0] == 2'b00) && (rom_address[31:2] < 30'd1432)) begin
            rom_rdata = rom_word(int'(rom_address[31:2]));
        end else begin
            rom_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One uncontended access from IDLE: grant, address, response, other port untouched.
    task automatic single(input logic port_d, input logic [31:0] addr,
                          input logic exp_e, input logic [31:0] exp_data, input string tag);
        tick();
        if (port_d) begin
            d_req  = 1'b1;
            d_addr = addr;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        #1;
        chk1({tag, "_i_gnt"}, i_gnt, !port_d);
        chk1({tag, "_d_gnt"}, d_gnt, port_d);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk32({tag, "_rom_address"}, rom_address, addr);
        chk1({tag, "_i_rvalid_early"}, i_rvalid, 1'b0);
        chk1({tag, "_d_rvalid_early"}, d_rvalid, 1'b0);
        tick();
        #1;
        if (port_d) begin
            exp_d_rdata = exp_data;
            chk1({tag, "_d_rvalid"}, d_rvalid, 1'b1);
            chk1({tag, "_d_err"}, d_err, exp_e);
            chk32({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
            chk1({tag, "_i_rvalid"}, i_rvalid, 1'b0);
            chk32({tag, "_i_rdata_held"}, i_rdata, exp_i_rdata);
        end else begin
            exp_i_rdata = exp_data;
            chk1({tag, "_i_rvalid"}, i_rvalid, 1'b1);
            chk1({tag, "_i_err"}, i_err, exp_e);
            chk32({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
            chk1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
            chk32({tag, "_d_rdata_held"}, d_rdata, exp_d_rdata);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_i_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        nreset      = 1'b0;
        i_req       = 1'b1;
        d_req       = 1'b0;
        i_addr      = 32'd0;
        d_addr      = 32'd0;

        // Reset state, with a request pending that must not be granted.
        tick();
        tick();
        #1;
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk32("rst_rom_address", rom_address, 32'd0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_i_rdata", i_rdata, 32'd0);
        chk32("rst_d_rdata", d_rdata, 32'd0);
        chk1("rst_i_err", i_err, 1'b0);
        chk1("rst_d_err", d_err, 1'b0);
        i_req  = 1'b0;
        nreset = 1'b1;

        // Port I only, word 2; then rvalid must drop while data holds.
        single(1'b0, 32'h0000_0008, 1'b0, rom_word(2), "i_only");
        tick();
        #1;
        chk1("i_only_rvalid_pulse", i_rvalid, 1'b0);
        chk32("i_only_rdata_hold", i_rdata, rom_word(2));

        // Continuous contention after reset: I, D, I, D grants at cycles 0, 2, 4, 6.
        nreset = 1'b0;
        tick();
        nreset      = 1'b1;
        exp_i_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        i_addr      = 32'h0000_0000;
        d_addr      = 32'h0000_0004;
        for (int k = 0; k <= 8; k++) begin
            if (k != 0) begin
                tick();
            end
            i_req = (k < 8);
            d_req = (k < 8);
            #1;
            chk1($sformatf("rr_i_gnt_c%0d", k), i_gnt,
                 (k < 8) && (k % 2 == 0) && ((k / 2) % 2 == 0));
            chk1($sformatf("rr_d_gnt_c%0d", k), d_gnt,
                 (k < 8) && (k % 2 == 0) && ((k / 2) % 2 == 1));
            chk1($sformatf("rr_i_rvalid_c%0d", k), i_rvalid,
                 (k >= 2) && (k % 2 == 0) && (((k - 2) / 2) % 2 == 0));
            chk1($sformatf("rr_d_rvalid_c%0d", k), d_rvalid,
                 (k >= 2) && (k % 2 == 0) && (((k - 2) / 2) % 2 == 1));
            if (k >= 2) begin
                exp_i_rdata = rom_word(0);
                chk32($sformatf("rr_i_rdata_c%0d", k), i_rdata, exp_i_rdata);
            end
            if (k >= 4) begin
                exp_d_rdata = rom_word(1);
                chk32($sformatf("rr_d_rdata_c%0d", k), d_rdata, exp_d_rdata);
            end
        end

        // Error and range boundary cases.
        single(1'b1, 32'h0000_0006, 1'b1, 32'd0, "d_misaligned");
        single(1'b1, 32'h0000_1660, 1'b1, 32'd0, "d_out_of_range");
        single(1'b1, 32'h0000_165C, 1'b0, rom_word(1431), "d_last_word");
        single(1'b0, 32'h0000_0001, 1'b1, 32'd0, "i_misaligned");
        single(1'b0, 32'h0000_1660, 1'b1, 32'd0, "i_out_of_range");
        single(1'b0, 32'h0000_0010, 1'b0, rom_word(4), "i_word4");

        // Reset during the ACCESS cycle of a port I read.
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_000C;
        #1;
        chk1("mid_i_gnt", i_gnt, 1'b1);
        tick();
        i_req  = 1'b0;
        nreset = 1'b0;
        #1;
        tick();
        #1;
        chk1("mid_i_rvalid", i_rvalid, 1'b0);
        chk32("mid_i_rdata", i_rdata, 32'd0);
        chk1("mid_i_err", i_err, 1'b0);
        chk1("mid_d_rvalid", d_rvalid, 1'b0);
        chk32("mid_d_rdata", d_rdata, 32'd0);
        chk1("mid_d_err", d_err, 1'b0);
        chk32("mid_rom_address", rom_address, 32'd0);
        nreset = 1'b1;
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h0000_0000;
        d_addr = 32'h0000_0004;
        #1;
        chk1("mid_tie_i_gnt", i_gnt, 1'b1);
        chk1("mid_tie_d_gnt", d_gnt, 1'b0);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        #1;
        chk1("mid_tie_i_rvalid", i_rvalid, 1'b1);
        chk32("mid_tie_i_rdata", i_rdata, rom_word(0));

`ifdef ROM_ARB_STATS_EN
        // Six contended grants (three pairs), then one misaligned D access.
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k != 0) begin
                tick();
            end
            i_req = (k < 11);
            d_req = (k < 11);
        end
        tick();
        d_req  = 1'b1;
        d_addr = 32'h0000_0006;
        #1;
        chk1("st_d_gnt", d_gnt, 1'b1);
        tick();
        d_req = 1'b0;
        tick();
        #1;
        chk1("st_d_err", d_err, 1'b1);
        chk32("st_i_count", i_count, 32'd3);
        chk32("st_d_count", d_count, 32'd4);
        chk32("st_conflict_count", conflict_count, 32'd6);
        chk32("st_err_count", {16'd0, err_count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
